// File: rtl/mod_memstage_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_memstage_if
// Brief    : Handshake, memory and execute-side signal bundle for mod_memstage.
// Revision : 1.0 - initial release
// ============================================================================
interface mod_memstage_if #(
   parameter int MEMEX_W = 278
) (
   input logic clk,
   input logic reset
);
   logic               in_valid;
   logic               in_ready;
   logic [MEMEX_W-1:0] in_memex;
   logic [1:0]         in_mem_op;
   logic [63:0]        in_addr;
   logic               mem_req;
   logic               mem_we;
   logic [63:0]        mem_addr;
   logic [63:0]        mem_wdata;
   logic               mem_ack;
   logic [63:0]        mem_rdata;
   logic [MEMEX_W-1:0] memex;
   logic               can_execute;
   logic               ex_ready;
   logic [63:0]        load_buffer;
   logic               loadbuffer_done;
   logic               memstage_active;
   logic               store_memstage_active;

   modport master (
      input  clk, reset,
      input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, memex, can_execute,
      input  load_buffer, loadbuffer_done, memstage_active, store_memstage_active,
      output in_valid, in_memex, in_mem_op, in_addr, mem_ack, mem_rdata, ex_ready
   );

   modport slave (
      input  in_valid, in_memex, in_mem_op, in_addr, mem_ack, mem_rdata, ex_ready,
      output in_ready, mem_req, mem_we, mem_addr, mem_wdata, memex, can_execute,
      output load_buffer, loadbuffer_done, memstage_active, store_memstage_active
   );
endinterface
`default_nettype wire

// File: rtl/mod_memstage.sv
`default_nettype none
// ============================================================================
// Module   : mod_memstage
// Brief    : Memory stage: issues one 8-byte load/store, then holds the
//            instruction for execute with back-to-back acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module mod_memstage #(
   parameter int MEMEX_W = 278
) (
   input  logic          clk,
   input  logic          reset,
   mod_memstage_if.slave bus
);
   // Field offsets inside the packed MEM_EX word (pc at the MSB end, mod at bit 0)
   localparam int         c_SIM_END_BIT = 2;
   localparam int         c_REGA_LSB    = 150;
   localparam logic [1:0] c_OP_LOAD     = 2'd1;
   localparam logic [1:0] c_OP_STORE    = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEM_REQ = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_is_mem;
   logic               w_ack;
   logic               w_mem_req;
   logic               w_active;
   logic [MEMEX_W-1:0] r_memex;
   logic [63:0]        r_addr;
   logic [63:0]        r_wdata;
   logic               r_store;
   logic [63:0]        r_load_buffer;
   logic               r_lb_done;
   logic               r_first_hold;

   // sim_end forces the instruction straight through without touching memory
   assign w_is_mem  = ((bus.in_mem_op == c_OP_LOAD) || (bus.in_mem_op == c_OP_STORE))
                      && !bus.in_memex[c_SIM_END_BIT];
   assign w_accept  = bus.in_valid & w_in_ready;
   assign w_mem_req = (r_state == MEM_REQ);
   assign w_ack     = w_mem_req & bus.mem_ack;

   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_next = w_is_mem ? MEM_REQ : HOLD;
         end
         MEM_REQ: begin
            if (bus.mem_ack) w_next = HOLD;
         end
         HOLD: begin
            w_in_ready = bus.ex_ready;
            if (bus.ex_ready) begin
               if (!bus.in_valid) w_next = IDLE;
               else               w_next = w_is_mem ? MEM_REQ : HOLD;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_memex       <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_store       <= 1'b0;
         r_load_buffer <= '0;
         r_lb_done     <= 1'b0;
         r_first_hold  <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_lb_done    <= w_ack & ~r_store;
         r_first_hold <= w_ack;
         if (w_ack && !r_store) r_load_buffer <= bus.mem_rdata;
         if (w_accept) begin
            r_memex <= bus.in_memex;
            r_addr  <= bus.in_addr;
            r_wdata <= bus.in_memex[c_REGA_LSB +: 64];
            r_store <= (bus.in_mem_op == c_OP_STORE);
         end
      end
   end

   // r_store still describes the in-flight op during the first HOLD cycle,
   // even if a new instruction is accepted in that same cycle
   assign w_active                  = w_mem_req | r_first_hold;
   assign bus.in_ready              = w_in_ready;
   assign bus.mem_req               = w_mem_req;
   assign bus.mem_we                = w_mem_req & r_store;
   assign bus.mem_addr              = r_addr;
   assign bus.mem_wdata             = r_wdata;
   assign bus.memex                 = r_memex;
   assign bus.can_execute           = (r_state == HOLD);
   assign bus.load_buffer           = r_load_buffer;
   assign bus.loadbuffer_done       = r_lb_done;
   assign bus.memstage_active       = w_active;
   assign bus.store_memstage_active = w_active & r_store;
endmodule
`default_nettype wire

// File: tb/tb_mod_memstage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_memstage
// Brief    : Transaction-timeline reference checker for mod_memstage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_memstage;
   localparam int MW = 278;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mod_memstage_if #(.MEMEX_W(MW)) bus (.clk(clk), .reset(reset));
   mod_memstage #(.MEMEX_W(MW)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_asserts = 0;
   int n_fail    = 0;

   // Expected outputs for the current cycle
   logic          exp_on = 1'b0;
   logic          exp_in_ready, exp_can, exp_req, exp_we, exp_lbd, exp_act, exp_sact;
   logic [63:0]   exp_addr, exp_wdata, exp_lb;
   logic [MW-1:0] exp_memex;

   // Transaction model state
   bit            m_hold, m_first, m_mem, m_store;
   logic [63:0]   m_addr, m_wdata;

   // Observation counters for directed literal checks
   int            cnt_req, cnt_lbd, cnt_sact, cnt_can;
   logic [63:0]   last_addr, last_wdata;
   logic          last_we;
   logic [MW-1:0] last_memex;

   task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_asserts++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_on) begin
         chk("in_ready",    MW'(bus.in_ready),              MW'(exp_in_ready));
         chk("can_execute", MW'(bus.can_execute),           MW'(exp_can));
         chk("mem_req",     MW'(bus.mem_req),               MW'(exp_req));
         chk("mem_we",      MW'(bus.mem_we),                MW'(exp_we));
         chk("lb_done",     MW'(bus.loadbuffer_done),       MW'(exp_lbd));
         chk("active",      MW'(bus.memstage_active),       MW'(exp_act));
         chk("st_active",   MW'(bus.store_memstage_active), MW'(exp_sact));
         chk("load_buffer", MW'(bus.load_buffer),           MW'(exp_lb));
         chk("memex",       bus.memex,                      exp_memex);
         if (exp_req) begin
            chk("mem_addr",  MW'(bus.mem_addr),  MW'(exp_addr));
            chk("mem_wdata", MW'(bus.mem_wdata), MW'(exp_wdata));
         end
      end
      cnt_req  += int'(bus.mem_req);
      cnt_lbd  += int'(bus.loadbuffer_done);
      cnt_sact += int'(bus.store_memstage_active);
      cnt_can  += int'(bus.can_execute);
      if (bus.mem_req === 1'b1) begin
         last_addr  = bus.mem_addr;
         last_wdata = bus.mem_wdata;
         last_we    = bus.mem_we;
      end
      if (bus.can_execute === 1'b1) last_memex = bus.memex;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cnt();
      cnt_req = 0; cnt_lbd = 0; cnt_sact = 0; cnt_can = 0;
   endtask

   task automatic set_idle();
      exp_in_ready = 1'b1; exp_can = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
      exp_lbd = 1'b0; exp_act = 1'b0; exp_sact = 1'b0;
   endtask

   task automatic set_req(input bit st);
      exp_in_ready = 1'b0; exp_can = 1'b0; exp_req = 1'b1; exp_we = st;
      exp_addr = m_addr; exp_wdata = m_wdata;
      exp_lbd = 1'b0; exp_act = 1'b1; exp_sact = st;
   endtask

   task automatic set_hold(input bit first, input bit rdy);
      exp_in_ready = rdy; exp_can = 1'b1; exp_req = 1'b0; exp_we = 1'b0;
      exp_lbd  = first & m_mem & !m_store;
      exp_act  = first & m_mem;
      exp_sact = first & m_mem & m_store;
   endtask

   function automatic logic [MW-1:0] make_memex(input logic [7:0] opc, input logic [63:0] rega,
                                                input bit se);
      logic [MW-1:0] v;
      v = '0;
      for (int i = 0; i < 9; i++) v = {v[MW-33:0], 32'($urandom)};
      v[21:14]   = opc;
      v[213:150] = rega;
      v[2]       = se;
      return v;
   endfunction

   function automatic logic [63:0] r64();
      return {32'($urandom), 32'($urandom)};
   endfunction

   // One instruction: accept, optional memory access, HOLD with stalls, then
   // either leave the final HOLD cycle to the next instruction or drain to IDLE.
   task automatic txn(input logic [MW-1:0] mx, input logic [1:0] op, input logic [63:0] addr,
                      input logic [63:0] rdata, input int n_req, input int n_wait,
                      input bit b2b, input int n_idle);
      if (m_hold) set_hold(m_first, 1'b1); else set_idle();
      bus.ex_ready  = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_memex  = mx;
      bus.in_mem_op = op;
      bus.in_addr   = addr;
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = r64();
      step();
      m_hold    = 1'b0;
      m_mem     = ((op == 2'd1) || (op == 2'd2)) && !mx[2];
      m_store   = m_mem && (op == 2'd2);
      m_addr    = addr;
      m_wdata   = mx[213:150];
      exp_memex = mx;
      if (m_mem) begin
         for (int k = 1; k <= n_req; k++) begin
            set_req(m_store);
            bus.in_valid  = 1'($urandom);
            bus.in_memex  = make_memex(8'($urandom), r64(), 1'b0);
            bus.in_mem_op = 2'($urandom);
            bus.in_addr   = r64();
            bus.ex_ready  = 1'($urandom);
            bus.mem_ack   = (k == n_req);
            bus.mem_rdata = (k == n_req) ? rdata : r64();
            step();
         end
         if (!m_store) exp_lb = rdata;
      end
      for (int h = 0; h < n_wait; h++) begin
         set_hold(h == 0, 1'b0);
         bus.ex_ready  = 1'b0;
         bus.in_valid  = 1'b1;
         bus.in_memex  = make_memex(8'($urandom), r64(), 1'b0);
         bus.in_mem_op = 2'($urandom);
         bus.in_addr   = r64();
         bus.mem_ack   = 1'($urandom);
         bus.mem_rdata = r64();
         step();
      end
      if (b2b) begin
         m_hold  = 1'b1;
         m_first = (n_wait == 0);
      end else begin
         set_hold(n_wait == 0, 1'b1);
         bus.ex_ready = 1'b1;
         bus.in_valid = 1'b0;
         bus.mem_ack  = 1'($urandom);
         step();
         for (int i = 0; i < n_idle; i++) begin
            set_idle();
            bus.in_valid = 1'b0;
            bus.mem_ack  = 1'($urandom);
            bus.ex_ready = 1'($urandom);
            step();
         end
      end
   endtask

   initial begin
      logic [MW-1:0] mx;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_memex  = '0;
      bus.in_mem_op = 2'd0;
      bus.in_addr   = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      bus.ex_ready  = 1'b0;
      m_hold = 1'b0; m_first = 1'b0; m_mem = 1'b0; m_store = 1'b0;
      m_addr = '0; m_wdata = '0;
      exp_memex = '0; exp_lb = '0; exp_addr = '0; exp_wdata = '0;
      last_addr = '0; last_wdata = '0; last_we = 1'b0; last_memex = '0;
      clr_cnt();
      step();
      set_idle();
      exp_on = 1'b1;
      step();
      reset = 1'b0;

      // Reset in the second request cycle of a load, then a late ack
      set_idle();
      mx = make_memex(8'h11, 64'h77, 1'b0);
      bus.in_valid = 1'b1; bus.in_memex = mx; bus.in_mem_op = 2'd1; bus.in_addr = 64'h3000;
      step();
      bus.in_valid = 1'b0; exp_memex = mx; m_addr = 64'h3000; m_wdata = 64'h77;
      set_req(1'b0);
      step();
      reset = 1'b1;
      set_req(1'b0);
      step();
      reset = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 64'hFFFF_0000_FFFF_0000;
      set_idle(); exp_memex = '0; exp_lb = '0;
      step();
      bus.mem_ack = 1'b0;
      set_idle();
      step();
      chk("d043_load_buffer", MW'(bus.load_buffer), '0);
      chk("d043_mem_req",     MW'(bus.mem_req),     '0);

      // Non-memory opcode 0x90
      clr_cnt();
      txn(make_memex(8'h90, r64(), 1'b0), 2'd0, r64(), r64(), 1, 0, 1'b0, 1);
      chk("d039_opcode", MW'(last_memex[21:14]), MW'(8'h90));
      chk("d039_req_cycles", MW'(cnt_req), '0);
      chk("d039_can_cycles", MW'(cnt_can), MW'(1));

      // Load, ack after 3 request cycles
      clr_cnt();
      txn(make_memex(8'h03, r64(), 1'b0), 2'd1, 64'h1000, 64'hDEADBEEF_00000001, 3, 0, 1'b0, 0);
      chk("d040_req_cycles", MW'(cnt_req), MW'(3));
      chk("d040_we",         MW'(last_we), '0);
      chk("d040_addr",       MW'(last_addr), MW'(64'h1000));
      chk("d040_lb",         MW'(bus.load_buffer), MW'(64'hDEADBEEF_00000001));
      chk("d040_lbd_pulses", MW'(cnt_lbd), MW'(1));

      // Store, immediate ack
      clr_cnt();
      txn(make_memex(8'h23, 64'h55, 1'b0), 2'd2, 64'h2008, r64(), 1, 0, 1'b0, 0);
      chk("d041_we",       MW'(last_we), MW'(1));
      chk("d041_wdata",    MW'(last_wdata), MW'(64'h55));
      chk("d041_addr",     MW'(last_addr), MW'(64'h2008));
      chk("d041_st_cycles", MW'(cnt_sact), MW'(2));
      chk("d041_lb",       MW'(bus.load_buffer), MW'(64'hDEADBEEF_00000001));

      // Four stalled HOLD cycles, then back-to-back load
      clr_cnt();
      txn(make_memex(8'h42, r64(), 1'b0), 2'd0, r64(), r64(), 1, 4, 1'b1, 0);
      txn(make_memex(8'h43, r64(), 1'b0), 2'd1, r64(), r64(), 2, 0, 1'b0, 0);
      chk("d042_can_cycles", MW'(cnt_can), MW'(6));
      chk("d042_req_cycles", MW'(cnt_req), MW'(2));

      // Load carrying sim_end
      clr_cnt();
      txn(make_memex(8'h03, r64(), 1'b1), 2'd1, r64(), r64(), 2, 0, 1'b0, 0);
      chk("d044_req_cycles", MW'(cnt_req), '0);
      chk("d044_sim_end",    MW'(last_memex[2]), MW'(1));
      chk("d044_lbd_pulses", MW'(cnt_lbd), '0);

      for (int t = 0; t < 80; t++) begin
         txn(make_memex(8'($urandom), r64(), ($urandom % 8) == 0), 2'($urandom), r64(), r64(),
             1 + int'($urandom % 4), int'($urandom % 4), 1'($urandom), int'($urandom % 3));
      end

      if (m_hold) begin
         set_hold(m_first, 1'b1);
         bus.ex_ready = 1'b1;
         bus.in_valid = 1'b0;
         step();
         m_hold = 1'b0;
      end
      set_idle();
      step();
      step();
      exp_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
